// File: rtl/spi_ram_irq_v.sv
// SPI RAM read/write slave with debounced buttons, request channels and a maskable IRQ register.
// Optional feature macro: SPI_RAM_IRQ_REQ_EN builds the request channels, type registers and overrun bit.

module spirw_slave_v #(
  parameter int c_addr_bits        = 32,
  parameter int c_sclk_capable_pin = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   csn,
  input  logic                   sclk,
  input  logic                   mosi,
  output logic                   miso_d,
  output logic                   rd,
  output logic                   wr,
  output logic [c_addr_bits-1:0] addr,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out
);
  logic       csn_m, csn_s, sclk_m, sclk_s, sclk_q, mosi_m, mosi_s;
  logic       sclk_v, mosi_v, sclk_rise, is_read, rd_d;
  logic [2:0] bit_cnt, byte_cnt;
  logic [6:0] rx_sr;
  logic [7:0] rx_next, tx_sr, rdata_q;

  // A clock-capable sclk pin tolerates a single synchroniser stage.
  assign sclk_v    = (c_sclk_capable_pin != 0) ? sclk_m : sclk_s;
  assign mosi_v    = (c_sclk_capable_pin != 0) ? mosi_m : mosi_s;
  assign sclk_rise = sclk_v & ~sclk_q & ~csn_s;
  assign rx_next   = {rx_sr, mosi_v};
  assign miso_d    = tx_sr[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      {csn_m, csn_s} <= 2'b11;
      {sclk_m, sclk_s, sclk_q, mosi_m, mosi_s} <= '0;
      bit_cnt <= '0; byte_cnt <= '0; rx_sr <= '0; tx_sr <= '0; rdata_q <= '0;
      is_read <= 1'b0; rd <= 1'b0; rd_d <= 1'b0; wr <= 1'b0;
      addr <= '0; data_out <= '0;
    end else begin
      csn_m <= csn;   csn_s <= csn_m;
      sclk_m <= sclk; sclk_s <= sclk_m; sclk_q <= sclk_v;
      mosi_m <= mosi; mosi_s <= mosi_m;
      if (csn_s) begin
        bit_cnt <= '0; byte_cnt <= '0; tx_sr <= '0;
        rd <= 1'b0; rd_d <= 1'b0; wr <= 1'b0;
      end else begin
        wr   <= 1'b0;
        rd_d <= rd;
        if (wr) addr <= addr + {{(c_addr_bits-1){1'b0}}, 1'b1};
        // Read data is captured once, on the first rd cycle, so it matches the IRQ snapshot.
        if (rd && !rd_d) rdata_q <= data_in;
        if (sclk_rise) begin
          rx_sr   <= rx_next[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          tx_sr   <= {tx_sr[6:0], 1'b0};
          if (bit_cnt == 3'd7) begin
            if (byte_cnt != 3'd6) byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd0) begin
              is_read <= rx_next[0];
            end else if (byte_cnt <= 3'd4) begin
              addr <= {addr[c_addr_bits-9:0], rx_next};
              if (byte_cnt == 3'd4 && is_read) rd <= 1'b1;
            end else if (!is_read) begin
              data_out <= rx_next;
              wr       <= 1'b1;
            end else if (byte_cnt == 3'd5) begin
              // Single fetch per read so read-to-clear never fires on a speculative prefetch.
              rd    <= 1'b0;
              tx_sr <= rdata_q;
            end
          end
        end
      end
    end
  end
endmodule

module spi_ram_irq_v #(
  parameter logic [7:0] c_addr_btn         = 8'hFB,
  parameter logic [7:0] c_addr_irq         = 8'hF1,
  parameter logic [7:0] c_addr_req         = 8'hD0,
  parameter int         c_btn_bits         = 7,
  parameter int         c_req_channels     = 2,
  parameter int         c_debounce_bits    = 20,
  parameter int         c_addr_bits        = 32,
  parameter int         c_sclk_capable_pin = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        csn,
  input  logic                        sclk,
  input  logic                        mosi,
  inout  wire                         miso,
  input  logic [c_btn_bits-1:0]       btn,
  input  logic [c_req_channels-1:0]   req,
  input  logic [8*c_req_channels-1:0] req_type,
  output logic                        irq,
  output logic                        rd,
  output logic                        wr,
  output logic [c_addr_bits-1:0]      addr,
  input  logic [7:0]                  data_in,
  output logic [7:0]                  data_out
);
  logic [7:0]                 pending, mask, snapshot, set_vec, pend_next, spi_rdata, spi_wdata, addr_hi;
  logic [c_btn_bits-1:0]      btn_m, btn_sync, btn_state;
  logic [c_debounce_bits-1:0] deb_cnt;
  logic                       rd_prev, rd_rise, rd_fall, is_irq, is_btn, is_reg, btn_accept, miso_d;

  spirw_slave_v #(.c_addr_bits(c_addr_bits), .c_sclk_capable_pin(c_sclk_capable_pin)) u_spi (
    .clk(clk), .reset(reset), .csn(csn), .sclk(sclk), .mosi(mosi), .miso_d(miso_d),
    .rd(rd), .wr(wr), .addr(addr), .data_in(spi_rdata), .data_out(spi_wdata)
  );

  assign miso    = csn ? 1'bz : miso_d;
  assign addr_hi = addr[c_addr_bits-1 -: 8];
  assign is_irq  = (addr_hi == c_addr_irq);
  assign is_btn  = (addr_hi == c_addr_btn);
  assign rd_rise = rd & ~rd_prev;
  assign rd_fall = ~rd & rd_prev;
  assign btn_accept = (btn_sync != btn_state) && deb_cnt[c_debounce_bits-1] && !pending[7];

`ifdef SPI_RAM_IRQ_REQ_EN
  logic [c_req_channels-1:0] req_s, req_q, req_rise;
  logic [7:0]                type_reg [c_req_channels];
  logic [7:0]                type_rd;
  logic                      is_req;

  assign is_req   = (addr_hi == c_addr_req);
  assign req_rise = req_s & ~req_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_s <= '0;
      req_q <= '0;
      for (int i = 0; i < c_req_channels; i++) type_reg[i] <= '0;
    end else begin
      req_s <= req;
      req_q <= req_s;
      for (int i = 0; i < c_req_channels; i++)
        if (req_rise[i]) type_reg[i] <= req_type[8*i +: 8];
    end
  end

  always_comb begin
    type_rd = '0;
    for (int i = 0; i < c_req_channels; i++)
      if (addr[7:0] == 8'(i)) type_rd = type_reg[i];
  end
`else
  logic unused_req;
  assign unused_req = ^{req, req_type};
`endif

  always_comb begin
    set_vec    = '0;
    set_vec[7] = btn_accept;
`ifdef SPI_RAM_IRQ_REQ_EN
    set_vec[c_req_channels-1:0] = req_rise;
    set_vec[6] = |(req_rise & pending[c_req_channels-1:0]);
`endif
    // Set after clear: a new event in the clearing cycle survives.
    pend_next = (rd_fall ? (pending & ~snapshot) : pending) | set_vec;
  end

  always_comb begin
    spi_rdata = data_in;
    is_reg    = is_irq | is_btn;
    if (is_irq) begin
      spi_rdata = pending & mask;
    end else if (is_btn) begin
      spi_rdata = '0;
      spi_rdata[c_btn_bits-1:0] = btn_state;
    end
`ifdef SPI_RAM_IRQ_REQ_EN
    else if (is_req) spi_rdata = type_rd;
    is_reg = is_reg | is_req;
`endif
    data_out = is_reg ? 8'h00 : spi_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_m <= '0; btn_sync <= '0; btn_state <= '0; deb_cnt <= '0;
      pending <= '0; mask <= 8'hFF; snapshot <= '0; rd_prev <= 1'b0; irq <= 1'b0;
    end else begin
      btn_m    <= btn;
      btn_sync <= btn_m;
      rd_prev  <= rd;
      pending  <= pend_next;
      irq      <= |(pending & mask);
      if (btn_accept) begin
        btn_state <= btn_sync;
        deb_cnt   <= '0;
      end else if (!deb_cnt[c_debounce_bits-1]) begin
        deb_cnt <= deb_cnt + {{(c_debounce_bits-1){1'b0}}, 1'b1};
      end
      if (rd_rise && is_irq) snapshot <= pending & mask;
      else if (rd_fall)      snapshot <= '0;
      if (wr && is_irq) mask <= spi_wdata;
    end
  end
endmodule

// File: tb/tb_spi_ram_irq_v.sv
// Self-checking bench for spi_ram_irq_v: SPI register/BRAM vectors plus IRQ corner sequences.
module tb_spi_ram_irq_v;
  logic        clk = 1'b0;
  logic        reset, csn, sclk, mosi;
  wire         miso;
  logic [6:0]  btn;
  logic [1:0]  req;
  logic [15:0] req_type;
  logic        irq, rd, wr;
  logic [31:0] addr;
  logic [7:0]  data_in, data_out;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SPI_RAM_IRQ_REQ_EN
  localparam bit REQ_EN = 1'b1;
`else
  localparam bit REQ_EN = 1'b0;
`endif

  spi_ram_irq_v #(.c_debounce_bits(4)) dut (
    .clk(clk), .reset(reset), .csn(csn), .sclk(sclk), .mosi(mosi), .miso(miso),
    .btn(btn), .req(req), .req_type(req_type), .irq(irq), .rd(rd), .wr(wr),
    .addr(addr), .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  // BRAM stand-in: read data is a fixed function of the address.
  assign data_in = addr[7:0] ^ addr[15:8] ^ 8'hA5;

  logic [31:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [7:0]  exp_q[$];

  always @(negedge clk)
    if (wr) begin
      wr_addr_q.push_back(addr);
      wr_data_q.push_back(data_out);
    end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (6) @(negedge clk);
      rx[i] = miso;
      sclk = 1'b1;
      repeat (6) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_xfer(input bit is_rd, input logic [31:0] a, input logic [7:0] wd,
                          output logic [7:0] rdat);
    logic [7:0] junk;
    csn = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(is_rd ? 8'h01 : 8'h00, junk);
    for (int b = 3; b >= 0; b--) spi_byte(a[8*b +: 8], junk);
    if (is_rd) spi_byte(8'h00, junk);
    spi_byte(wd, rdat);
    repeat (4) @(negedge clk);
    csn = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic read_check(input string nm, input logic [31:0] a, input logic [7:0] exp);
    logic [7:0] d;
    exp_q.push_back(exp);
    spi_xfer(1'b1, a, 8'h00, d);
    if (exp_q.size() == 0) check({nm, " scoreboard"}, 32'd0, 32'd1);
    else check(nm, d, exp_q.pop_front());
  endtask

  task automatic write_check(input string nm, input logic [31:0] a, input logic [7:0] wd,
                             input logic [7:0] exp_bram);
    logic [7:0] d;
    spi_xfer(1'b0, a, wd, d);
    if (wr_addr_q.size() != 1) begin
      check({nm, " wr count"}, wr_addr_q.size(), 1);
      wr_addr_q.delete();
      wr_data_q.delete();
    end else begin
      check({nm, " addr"}, wr_addr_q.pop_front(), a);
      check({nm, " data"}, wr_data_q.pop_front(), exp_bram);
    end
  endtask

  task automatic wait_rd(input logic lvl, input string nm);
    int k = 0;
    while (rd !== lvl && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(nm, rd, lvl);
  endtask

  task automatic pulse_req(input int ch, input logic [7:0] t);
    req_type[8*ch +: 8] = t;
    req[ch] = 1'b1;
    repeat (2) @(negedge clk);
    req[ch] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] a;
    logic [7:0]  wd;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[8];

  initial begin : global_timeout
    #600000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 32'hFB000000, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 32'h00000010, 8'h00, 8'hB5};
    vecs[2] = '{1'b0, 32'h12345678, 8'h00, 8'h8B};
    vecs[3] = '{1'b0, 32'hFC0000AB, 8'h00, 8'h0E};
    vecs[4] = '{1'b0, 32'hF0001234, 8'h00, 8'h83};
    vecs[5] = '{1'b1, 32'h00000100, 8'h3C, 8'h3C};
    vecs[6] = '{1'b1, 32'h8000FFFF, 8'hC3, 8'hC3};
    vecs[7] = '{1'b1, 32'hFB000000, 8'h77, 8'h00};

    reset = 1'b1; csn = 1'b1; sclk = 1'b0; mosi = 1'b0;
    btn = '0; req = '0; req_type = '0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("reset irq", irq, 1'b0);
    check("reset rd/wr", {rd, wr}, 2'b00);
    read_check("reset irq reg", 32'hF1000000, 8'h00);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_wr) write_check($sformatf("vec%0d wr", i), vecs[i].a, vecs[i].wd, vecs[i].exp);
      else               read_check($sformatf("vec%0d rd", i), vecs[i].a, vecs[i].exp);
    end

    // Button press, read and clear with the 2-clk irq drop after rd falls.
    btn = 7'h05;
    repeat (12) @(negedge clk);
    check("btn irq", irq, 1'b1);
    read_check("btn reg", 32'hFB000000, 8'h05);
    fork
      read_check("btn irq reg", 32'hF1000000, 8'h80);
      begin
        wait_rd(1'b1, "btn rd rise");
        wait_rd(1'b0, "btn rd fall");
        repeat (2) @(negedge clk);
        check("btn irq cleared", irq, 1'b0);
      end
    join

    // Single request on channel 1.
    pulse_req(1, 8'h2A);
    check("req1 irq", irq, REQ_EN);
    read_check("req1 type", 32'hD0000001, REQ_EN ? 8'h2A : 8'hA4);
    read_check("req1 irq reg", 32'hF1000000, REQ_EN ? 8'h02 : 8'h00);
    check("req1 irq cleared", irq, 1'b0);

    // Overrun on channel 0.
    pulse_req(0, 8'h11);
    pulse_req(0, 8'h22);
    read_check("ovr type", 32'hD0000000, REQ_EN ? 8'h22 : 8'hA5);
    read_check("ovr irq reg", 32'hF1000000, REQ_EN ? 8'h41 : 8'h00);
    check("ovr irq cleared", irq, 1'b0);

    // Mask restricts irq to channel 0.
    write_check("mask01", 32'hF1000000, 8'h01, 8'h00);
    btn = 7'h00;
    repeat (12) @(negedge clk);
    check("masked btn irq", irq, 1'b0);
    pulse_req(0, 8'h33);
    check("mask req0 irq", irq, REQ_EN);
    read_check("masked irq reg", 32'hF1000000, REQ_EN ? 8'h01 : 8'h00);
    write_check("maskFF", 32'hF1000000, 8'hFF, 8'h00);
    check("unmasked btn irq", irq, 1'b1);
    read_check("unmasked irq reg", 32'hF1000000, 8'h80);
    check("unmasked irq cleared", irq, 1'b0);

    // Request arriving inside the rd window survives the clear.
    fork
      read_check("window irq reg", 32'hF1000000, 8'h00);
      begin
        wait_rd(1'b1, "window rd rise");
        repeat (3) @(negedge clk);
        req[0] = 1'b1;
        repeat (2) @(negedge clk);
        req[0] = 1'b0;
      end
    join
    check("window irq", irq, REQ_EN);
    read_check("window pending kept", 32'hF1000000, REQ_EN ? 8'h01 : 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_ram_irq_v.md
# spi_ram_irq_v

SPI RAM read/write slave with a generalised interrupt controller. It sits between the ESP32 SPI bus and the OSD/BRAM port. It wraps `spirw_slave_v` and adds:
- a parametrised debounced button bank;
- N external request channels (floppy-style), each with a latched type byte;
- a maskable, snapshot-cleared IRQ register driving `irq` to the ESP32.

All other addresses pass through to the BRAM interface.

## Interface
Parameters:
- c_addr_btn, 8'hFB, high address byte of the button register
- c_addr_irq, 8'hF1, high address byte of the IRQ flag/mask register
- c_addr_req, 8'hD0, high address byte of the request-type registers
- c_btn_bits, 7, button count, 1..8
- c_req_channels, 2, request channels, 1..6
- c_debounce_bits, 20, debounce counter width
- c_addr_bits, 32, SPI address width (fixed)
- c_sclk_capable_pin, 0, passed to `spirw_slave_v`

Ports:
- clk  in  1  system clock, faster than sclk
- reset  in  1  synchronous, active-high reset
- csn, sclk, mosi  in  1 each  SPI lines
- miso  inout  1  3-state, driven only while csn=0
- btn  in  c_btn_bits  raw buttons, asynchronous
- req  in  c_req_channels  request strobes, each ≥1 clk high
- req_type  in  8*c_req_channels  type byte per channel; channel i is [8i+7:8i]
- irq  out  1  interrupt to ESP32
- rd, wr  out  1 each  BRAM strobes from the SPI slave
- addr  out  c_addr_bits  BRAM address
- data_in  in  8  BRAM read data
- data_out  out  8  BRAM write data

## Operation
- Register read mux (combinational on addr[top 8]):
  - c_addr_irq → pending & mask;
  - c_addr_btn → {zero pad, btn_state};
  - c_addr_req → type register selected by addr[7:0] (index ≥ c_req_channels reads 0);
  - any other address → data_in.
- IRQ byte layout: bit7 = button, bit6 = request overrun, bits[c_req_channels-1:0] = request channel pending.
- Buttons:
  - btn is registered twice (2-FF sync) into btn_sync.
  - One shared debounce counter counts up and saturates with its MSB set.
  - When btn_sync≠btn_state, the counter MSB=1 and pending[7]=0: load btn_state←btn_sync, set pending[7], clear the counter.
- Requests:
  - A rising edge on req[i] sets pending[i] and latches req_type byte i.
  - If pending[i] is already 1, the type byte is overwritten and pending[6] is set.
- Read-clear:
  - On a rising rd with addr top byte = c_addr_irq, snapshot ← pending & mask.
  - On the falling rd, pending ← pending & ~snapshot. Events arriving between the two edges are kept.
- Mask write: wr with addr top byte = c_addr_irq loads mask←data_out. No data_out is forwarded to BRAM for register addresses; wr is still asserted.
- irq = |(pending & mask), registered.
- Simultaneous set and clear of the same bit in one cycle: set wins.

## Timing
- Reset values:
  - pending=0, mask=8'hFF, snapshot=0;
  - btn_state=0, debounce counter=0, req edge registers=0, type registers=0;
  - irq=0. Reset holds the internal SPI slave idle.
- Reset mid-transaction clears all of the above. The SPI slave resynchronises at the next csn falling edge.
- irq rises 1 clk after the cycle pending is set, and falls 1 clk after the clear or mask write.
- Request edge to pending: 2 clk (1 edge-detect register + set).
- Button latency: 2 sync clk + 1 compare clk, gated by the counter MSB. Minimum spacing between accepted changes is 2^(c_debounce_bits-1) clk.
- The first button change after reset is accepted no earlier than 2^(c_debounce_bits-1) clk.
- Read data follows the `spirw_slave_v` protocol: cmd 01, address, one dummy byte, then data.

## Configuration
- SPI_RAM_IRQ_REQ_EN
  - Defined: request channels, type registers and overrun bit are built as above.
  - Undefined: req/req_type are ignored; bits 6 and [c_req_channels-1:0] read 0 and are never set; c_addr_req reads pass through data_in.
  - Button and mask behaviour is identical in both builds.

## Test plan
Bench uses c_debounce_bits=4 and `SPI_RAM_IRQ_REQ_EN` defined unless stated.
- Reset, idle 20 clk, read 0xF1000000 → byte 8'h00; irq=0.
- Set btn 7'h00→7'h05; wait 12 clk → irq=1. Read 0xFB000000 → 8'h05. Read 0xF1 → 8'h80, then irq=0 within 2 clk of rd falling.
- Pulse req[1] with type 8'h2A → irq=1. Read 0xD0000001 → 8'h2A. Read 0xF1 → 8'h02, then cleared.
- Two req[0] pulses with no read between them (types 8'h11, 8'h22) → IRQ byte 8'h41; type reads 8'h22.
- Write mask 8'h01 to 0xF1000000, change a button → irq stays 0. Pulse req[0] → irq=1.
- Pulse req[0] between the rd rise and fall of an 0xF1 read → read returns 8'h00 and pending[0] remains 1 afterwards. Build without `SPI_RAM_IRQ_REQ_EN` → the same stimulus leaves irq=0.
